// File: rtl/anchor_pkg.sv
// Shared definitions for the anchor reset sequencer: state codes,
// default timing parameters and a constant-evaluable clog2.
package anchor_pkg;

   typedef enum logic [2:0] {
      ST_WAIT_LOCK = 3'd0,
      ST_STABLE    = 3'd1,
      ST_REL_M     = 3'd2,
      ST_REL_C     = 3'd3,
      ST_REL_D     = 3'd4,
      ST_RUN       = 3'd5
   } state_e;

   localparam int DEF_LOCK_STABLE_CYCLES = 1024;
   localparam int DEF_STAGE_GAP_CYCLES   = 16;

   // Number of bits needed to hold the values 0 .. value-1.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for an input asynchronous to clk.
// Both stages clear to 0 so a held reset reads as "not locked".
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic meta_d;
   logic sync_q;
   logic sync_d;

   // Next values simply shift the input one stage further down the chain.
   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   // Two metastability-settling stages cleared by the block reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/anchor_rst_seq.sv
// Reset sequencer behind the anchor clock generator: waits for both PLLs
// to be locked and stable, then releases main, compute and data domain
// resets in order, collapsing all of them on lock loss or soft reset.
module anchor_rst_seq
   import anchor_pkg::*;
#(
   parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
   parameter int STAGE_GAP_CYCLES   = DEF_STAGE_GAP_CYCLES,
   parameter int LOSS_CNT_W         = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pll0_lock,
   input  logic                  pll1_lock,
   input  logic                  soft_rst,
   output logic                  m_rst,
   output logic                  c_rst,
   output logic                  d_rst,
   output logic                  ready,
   output logic [2:0]            state,
   output logic [LOSS_CNT_W-1:0] loss_cnt
);

   // One counter serves both the lock debounce and the stage gaps, so it is
   // sized for the longer of the two and never has to count past it.
   localparam int MAX_CYCLES = (LOCK_STABLE_CYCLES > STAGE_GAP_CYCLES) ?
                               LOCK_STABLE_CYCLES : STAGE_GAP_CYCLES;
   localparam int CNT_W      = (clog2(MAX_CYCLES) < 1) ? 1 : clog2(MAX_CYCLES);
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP_CYCLES - 1);

   logic                  pll0_sync;
   logic                  pll1_sync;
   logic                  lock_s;
   logic                  released;

   logic [2:0]            state_q;
   logic [2:0]            state_d;
   logic [CNT_W-1:0]      cnt_q;
   logic [CNT_W-1:0]      cnt_d;
   logic [LOSS_CNT_W-1:0] loss_cnt_q;
   logic [LOSS_CNT_W-1:0] loss_cnt_d;
   logic                  m_rst_q;
   logic                  m_rst_d;
   logic                  c_rst_q;
   logic                  c_rst_d;
   logic                  d_rst_q;
   logic                  d_rst_d;
   logic                  ready_q;
   logic                  ready_d;

   sync_2ff u_sync_pll0 (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pll0_lock),
      .q     (pll0_sync)
   );

   sync_2ff u_sync_pll1 (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pll1_lock),
      .q     (pll1_sync)
   );

   assign lock_s = pll0_sync & pll1_sync;

   // State, counter and output flops all load on the same edge so the
   // reset pins change together with the reported state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_WAIT_LOCK;
         cnt_q      <= '0;
         loss_cnt_q <= '0;
         m_rst_q    <= 1'b1;
         c_rst_q    <= 1'b1;
         d_rst_q    <= 1'b1;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         loss_cnt_q <= loss_cnt_d;
         m_rst_q    <= m_rst_d;
         c_rst_q    <= c_rst_d;
         d_rst_q    <= d_rst_d;
         ready_q    <= ready_d;
      end
   end

   // Sequencing decisions: soft reset wins over everything, a drop of the
   // synchronized lock once release has begun is logged as a loss.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      loss_cnt_d = loss_cnt_q;
      released   = (state_q == ST_REL_M) || (state_q == ST_REL_C) ||
                   (state_q == ST_REL_D) || (state_q == ST_RUN);

      if (released && !lock_s && (loss_cnt_q != '1)) begin
         loss_cnt_d = loss_cnt_q + 1'b1;
      end

      if (soft_rst) begin
         state_d = ST_WAIT_LOCK;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_WAIT_LOCK: begin
               cnt_d = '0;
               if (lock_s) begin
                  state_d = ST_STABLE;
               end
            end
            ST_STABLE: begin
               if (!lock_s) begin
                  state_d = ST_WAIT_LOCK;
                  cnt_d   = '0;
               end else if (cnt_q == LOCK_LAST) begin
                  state_d = ST_REL_M;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_REL_M, ST_REL_C, ST_REL_D: begin
               if (!lock_s) begin
                  state_d = ST_WAIT_LOCK;
                  cnt_d   = '0;
               end else if (cnt_q == GAP_LAST) begin
                  cnt_d = '0;
                  if (state_q == ST_REL_M) begin
                     state_d = ST_REL_C;
                  end else if (state_q == ST_REL_C) begin
                     state_d = ST_REL_D;
                  end else begin
                     state_d = ST_RUN;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_RUN: begin
               if (!lock_s) begin
                  state_d = ST_WAIT_LOCK;
                  cnt_d   = '0;
               end
            end
            default: begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Reset pin values decoded from the upcoming state so the flops present
   // them in step with the state register.
   always_comb begin
      m_rst_d = 1'b1;
      c_rst_d = 1'b1;
      d_rst_d = 1'b1;
      ready_d = 1'b0;
      case (state_d)
         ST_REL_M: begin
            m_rst_d = 1'b0;
         end
         ST_REL_C: begin
            m_rst_d = 1'b0;
            c_rst_d = 1'b0;
         end
         ST_REL_D: begin
            m_rst_d = 1'b0;
            c_rst_d = 1'b0;
            d_rst_d = 1'b0;
         end
         ST_RUN: begin
            m_rst_d = 1'b0;
            c_rst_d = 1'b0;
            d_rst_d = 1'b0;
            ready_d = 1'b1;
         end
         default: begin
            m_rst_d = 1'b1;
         end
      endcase
   end

   assign m_rst    = m_rst_q;
   assign c_rst    = c_rst_q;
   assign d_rst    = d_rst_q;
   assign ready    = ready_q;
   assign state    = state_q;
   assign loss_cnt = loss_cnt_q;

endmodule

// File: tb/tb_anchor_rst_seq.sv
// Self-checking bench for anchor_rst_seq: directed scenarios plus random
// lock/soft-reset traffic, compared every cycle against an age-based model.
module tb_anchor_rst_seq;

   localparam int L       = 16;
   localparam int G       = 4;
   localparam int W       = 8;
   localparam int LOSSMAX = (1 << W) - 1;

   logic         clk;
   logic         rst_n;
   logic         pll0_lock;
   logic         pll1_lock;
   logic         soft_rst;
   logic         m_rst;
   logic         c_rst;
   logic         d_rst;
   logic         ready;
   logic [2:0]   state;
   logic [W-1:0] loss_cnt;

   int checks;
   int errors;

   // Model: age = edges since the sequence left WAIT_LOCK (-1 while waiting).
   int age;
   int loss;
   bit s1;
   bit s2;

   anchor_rst_seq #(
      .LOCK_STABLE_CYCLES (L),
      .STAGE_GAP_CYCLES   (G),
      .LOSS_CNT_W         (W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pll0_lock (pll0_lock),
      .pll1_lock (pll1_lock),
      .soft_rst  (soft_rst),
      .m_rst     (m_rst),
      .c_rst     (c_rst),
      .d_rst     (d_rst),
      .ready     (ready),
      .state     (state),
      .loss_cnt  (loss_cnt)
   );

   // 100 MHz main clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         errors = errors + 1;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int expState();
      if (age < 0) return 0;
      if (age < L) return 1;
      if (age < L + G) return 2;
      if (age < L + 2 * G) return 3;
      if (age < L + 3 * G) return 4;
      return 5;
   endfunction

   task automatic modelReset();
      age  = -1;
      loss = 0;
      s1   = 1'b0;
      s2   = 1'b0;
   endtask

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic modelStep();
      bit ls;
      if (!rst_n) begin
         modelReset();
      end else begin
         ls = s2;
         s2 = s1;
         s1 = pll0_lock & pll1_lock;
         if (soft_rst || (age >= 0 && !ls)) begin
            if (age >= L && !ls && loss < LOSSMAX) loss = loss + 1;
            age = -1;
         end else if (age < 0) begin
            if (ls) age = 0;
         end else if (age < L + 3 * G) begin
            age = age + 1;
         end
      end
   endtask

   task automatic checkAll();
      checkOutput("state", int'(state), expState());
      checkOutput("m_rst", int'(m_rst), (age >= L) ? 0 : 1);
      checkOutput("c_rst", int'(c_rst), (age >= L + G) ? 0 : 1);
      checkOutput("d_rst", int'(d_rst), (age >= L + 2 * G) ? 0 : 1);
      checkOutput("ready", int'(ready), (age >= L + 3 * G) ? 1 : 0);
      checkOutput("loss_cnt", int'(loss_cnt), loss);
   endtask

   // One clock cycle: drive on the falling edge, model on the rising edge,
   // compare just after it.
   task automatic applyStimulus(input logic a, input logic b, input logic s);
      @(negedge clk);
      pll0_lock = a;
      pll1_lock = b;
      soft_rst  = s;
      @(posedge clk);
      modelStep();
      #1;
      checkAll();
   endtask

   task automatic waitState(input int target, input int budget);
      int n;
      n = 0;
      while (int'(state) != target && n < budget) begin
         applyStimulus(1'b1, 1'b1, 1'b0);
         n = n + 1;
      end
      checkOutput("wait_state", int'(state), target);
   endtask

   initial begin
      int n;
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      pll0_lock = 1'b0;
      pll1_lock = 1'b0;
      soft_rst  = 1'b0;
      modelReset();

      // Reset values.
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("rst_state", int'(state), 0);
      checkOutput("rst_m_rst", int'(m_rst), 1);
      checkOutput("rst_ready", int'(ready), 0);
      rst_n = 1'b1;

      // Nominal sequence, edge numbers counted from lock rise.
      for (int i = 1; i <= 35; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0);
         if (i == 2)  checkOutput("nom_state_e2", int'(state), 0);
         if (i == 3)  checkOutput("nom_state_e3", int'(state), 1);
         if (i == 18) checkOutput("nom_m_rst_e18", int'(m_rst), 1);
         if (i == 19) checkOutput("nom_m_rst_e19", int'(m_rst), 0);
         if (i == 22) checkOutput("nom_c_rst_e22", int'(c_rst), 1);
         if (i == 23) checkOutput("nom_c_rst_e23", int'(c_rst), 0);
         if (i == 26) checkOutput("nom_d_rst_e26", int'(d_rst), 1);
         if (i == 27) checkOutput("nom_d_rst_e27", int'(d_rst), 0);
         if (i == 30) checkOutput("nom_ready_e30", int'(ready), 0);
         if (i == 31) checkOutput("nom_ready_e31", int'(ready), 1);
         if (i == 35) checkOutput("nom_loss", int'(loss_cnt), 0);
      end

      // Debounce: soft reset, count to 10 in STABLE, drop pll1 for 3 cycles.
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("deb_soft_state", int'(state), 0);
      repeat (11) applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("deb_stable", int'(state), 1);
      repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("deb_back_wait", int'(state), 0);
      checkOutput("deb_m_rst", int'(m_rst), 1);
      waitState(5, 80);
      checkOutput("deb_loss", int'(loss_cnt), 0);

      // Loss in RUN: resets collapse exactly three edges after the drop.
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("loss_ready_e2", int'(ready), 1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("loss_ready_e3", int'(ready), 0);
      checkOutput("loss_d_rst_e3", int'(d_rst), 1);
      checkOutput("loss_cnt_e3", int'(loss_cnt), 1);
      n = 0;
      while (!ready && n < 100) begin
         applyStimulus(1'b1, 1'b1, 1'b0);
         n = n + 1;
      end
      checkOutput("loss_restore_edges", n, 31);

      // Soft reset during REL_C.
      applyStimulus(1'b1, 1'b1, 1'b1);
      waitState(3, 60);
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("soft_state", int'(state), 0);
      checkOutput("soft_m_rst", int'(m_rst), 1);
      checkOutput("soft_loss", int'(loss_cnt), 1);
      waitState(5, 60);

      // Random lock drops and soft resets.
      for (int i = 0; i < 2500; i++) begin
         applyStimulus(logic'($urandom_range(0, 59) != 0),
                       logic'($urandom_range(0, 59) != 0),
                       logic'($urandom_range(0, 99) == 0));
      end

      // Saturation: 300 losses from RUN.
      for (int i = 0; i < 300; i++) begin
         waitState(5, 60);
         repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
      end
      checkOutput("sat_loss", int'(loss_cnt), LOSSMAX);

      // Asynchronous reset in the middle of REL_D, between clock edges.
      waitState(4, 60);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_m_rst", int'(m_rst), 1);
      checkOutput("arst_c_rst", int'(c_rst), 1);
      checkOutput("arst_d_rst", int'(d_rst), 1);
      checkOutput("arst_ready", int'(ready), 0);
      checkOutput("arst_state", int'(state), 0);
      checkOutput("arst_loss", int'(loss_cnt), 0);
      modelReset();
      applyStimulus(1'b1, 1'b1, 1'b0);
      rst_n = 1'b1;
      waitState(5, 60);
      checkOutput("arst_restart_loss", int'(loss_cnt), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
